// File: rtl/picorv32_ram_bridge.sv
// Bridge from the picorv32 native memory bus to a 1024x32 single-port RAM wrapper.
// Build option RAMBR_OOR_TRAP_EN adds a sticky oor_err flag and a 0xDEAD_BEEF out-of-range read value.
module picorv32_ram_bridge #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          AW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_valid,
  input  logic          mem_instr,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic [3:0]    mem_wstrb,
  output logic          mem_ready,
  output logic [31:0]   mem_rdata,
  output logic          ram_ce,
  output logic          ram_oce,
  output logic          ram_reset,
  output logic          ram_wre,
  output logic [AW-1:0] ram_ad,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout,
`ifdef RAMBR_OOR_TRAP_EN
  output logic          oor_err,
`endif
  output logic [1:0]    state_dbg
);

  // Handshake: a request is accepted only in IDLE while mem_valid=1; mem_ready
  // pulses for exactly one cycle (ACK) and the CPU drops mem_valid after it.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD    = 2'd1;
  localparam logic [1:0] MERGE = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          oor_q, oor_d;

  logic          in_range;
  logic [AW-1:0] word_idx;
  logic [31:0]   merged;
  logic          ce_c, wre_c;
  logic [AW-1:0] ad_c;
  logic [31:0]   din_c;
  logic [31:0]   oor_rdata;

  logic unused_ok;
  assign unused_ok = ^{mem_instr, mem_addr[1:0]};

  assign in_range = (mem_addr[31:AW+2] == ADDR_BASE[31:AW+2]);
  assign word_idx = mem_addr[AW+1:2];

`ifdef RAMBR_OOR_TRAP_EN
  assign oor_rdata = (mem_wstrb == 4'h0) ? 32'hDEAD_BEEF : 32'h0;
`else
  assign oor_rdata = 32'h0;
`endif

  always_comb begin
    merged = 32'h0;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : ram_dout[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    oor_d   = oor_q;
    ce_c    = 1'b0;
    wre_c   = 1'b0;
    ad_c    = addr_q;
    din_c   = 32'h0;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if (!in_range) begin
            rdata_d = oor_rdata;
            oor_d   = 1'b1;
            state_d = ACK;
          end else if (mem_wstrb == 4'h0) begin
            ce_c    = 1'b1;
            ad_c    = word_idx;
            addr_d  = word_idx;
            state_d = RD;
          end else if (mem_wstrb == 4'hF) begin
            ce_c    = 1'b1;
            wre_c   = 1'b1;
            ad_c    = word_idx;
            din_c   = mem_wdata;
            state_d = ACK;
          end else begin
            // Partial store: fetch the old word first, merge it next cycle.
            ce_c    = 1'b1;
            ad_c    = word_idx;
            addr_d  = word_idx;
            wdata_d = mem_wdata;
            wstrb_d = mem_wstrb;
            state_d = MERGE;
          end
        end
      end
      RD: begin
        rdata_d = ram_dout;
        state_d = ACK;
      end
      MERGE: begin
        ce_c    = 1'b1;
        wre_c   = 1'b1;
        ad_c    = addr_q;
        din_c   = merged;
        state_d = ACK;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      rdata_q <= 32'h0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      oor_q   <= oor_d;
    end
  end

  // Combinational RAM controls are gated by reset so an abort never writes.
  assign ram_ce    = ce_c & ~reset;
  assign ram_wre   = wre_c & ~reset;
  assign ram_ad    = ad_c;
  assign ram_din   = din_c;
  assign ram_oce   = 1'b1;
  assign ram_reset = reset;

  assign mem_ready = (state_q == ACK);
  assign mem_rdata = rdata_q;
  assign state_dbg = state_q;

`ifdef RAMBR_OOR_TRAP_EN
  assign oor_err = oor_q;
`else
  logic unused_oor;
  assign unused_oor = oor_q;
`endif

endmodule

// File: tb/tb_picorv32_ram_bridge.sv
// Directed bench for picorv32_ram_bridge with a behavioural 1024x32 RAM model.
module tb_picorv32_ram_bridge;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ram_ce;
  logic        ram_oce;
  logic        ram_reset;
  logic        ram_wre;
  logic [9:0]  ram_ad;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [1:0]  state_dbg;
`ifdef RAMBR_OOR_TRAP_EN
  logic        oor_err;
`endif

  int checks = 0;
  int errors = 0;

  picorv32_ram_bridge #(.ADDR_BASE(32'h0000_0000), .AW(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .ram_ce    (ram_ce),
    .ram_oce   (ram_oce),
    .ram_reset (ram_reset),
    .ram_wre   (ram_wre),
    .ram_ad    (ram_ad),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
`ifdef RAMBR_OOR_TRAP_EN
    .oor_err   (oor_err),
`endif
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model plus activity counters
  logic [31:0] ram_mem [0:1023];
  int ce_cnt = 0;
  int wr_cnt = 0;
  int last_wr = -1;
  int rdy_cnt = 0;
  int dbl_cnt = 0;
  logic rdy_prev = 1'b0;

  initial begin
    for (int i = 0; i < 1024; i++) ram_mem[i] = 32'h0;
    ram_dout = 32'h0;
  end

  always @(posedge clk) begin
    if (ram_ce) begin
      ce_cnt++;
      if (ram_wre) begin
        ram_mem[ram_ad] = ram_din;
        wr_cnt++;
        last_wr = int'(ram_ad);
      end else begin
        ram_dout <= ram_mem[ram_ad];
      end
    end
    if (mem_ready) rdy_cnt++;
    if (mem_ready && rdy_prev) dbl_cnt++;
    rdy_prev = mem_ready;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: cycle 0 is the cycle the request is first presented in IDLE
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input bit scramble,
                        output logic [31:0] rdata, output int lat);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_valid = 1'b1;
    lat = 0;
    while (!mem_ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (scramble && lat == 1) begin
        mem_wdata = 32'h5A5A_0FF0;
        mem_wstrb = 4'hF;
        mem_addr  = 32'h0000_0044;
      end
    end
    if (!mem_ready) check("ack_timeout", 32'd0, 32'd1);
    rdata     = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  int lat;
  int c0, w0, r0;

  initial begin
    reset = 1'b1;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_ce", {31'b0, ram_ce}, 32'd0);
    check("rst_wre", {31'b0, ram_wre}, 32'd0);
    check("rst_oce", {31'b0, ram_oce}, 32'd1);
    check("rst_ramreset", {31'b0, ram_reset}, 32'd1);
    check("rst_state", {30'b0, state_dbg}, 32'd0);
`ifdef RAMBR_OOR_TRAP_EN
    check("rst_oor", {31'b0, oor_err}, 32'd0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;
    check("ramreset_low", {31'b0, ram_reset}, 32'd0);

    // full store then read
    w0 = wr_cnt;
    do_req(32'h0000_0010, 32'h1234_5678, 4'hF, 1'b0, rd, lat);
    check("fs_lat", lat, 32'd1);
    check("fs_wr", wr_cnt - w0, 32'd1);
    check("fs_word4", ram_mem[4], 32'h1234_5678);
    check("fs_rdata_hold", rd, 32'h0);
    do_req(32'h0000_0010, 32'h0, 4'h0, 1'b0, rd, lat);
    check("rd_lat", lat, 32'd2);
    check("rd_data", rd, 32'h1234_5678);

    // byte RMW; inputs scrambled after acceptance must not matter
    c0 = ce_cnt; w0 = wr_cnt;
    do_req(32'h0000_0010, 32'h0000_AB00, 4'b0010, 1'b1, rd, lat);
    check("rmw_lat", lat, 32'd2);
    check("rmw_ce", ce_cnt - c0, 32'd2);
    check("rmw_wr", wr_cnt - w0, 32'd1);
    check("rmw_word17", ram_mem[17], 32'h0);
    do_req(32'h0000_0010, 32'h0, 4'h0, 1'b0, rd, lat);
    check("rmw_readback", rd, 32'h1234_AB78);

    // halfword store at top word
    do_req(32'h0000_0FFC, 32'h1111_2222, 4'hF, 1'b0, rd, lat);
    w0 = wr_cnt;
    do_req(32'h0000_0FFC, 32'hCAFE_0000, 4'b1100, 1'b0, rd, lat);
    check("hw_lat", lat, 32'd2);
    check("hw_wr", wr_cnt - w0, 32'd1);
    check("hw_idx", last_wr, 32'd1023);
    check("hw_word4_kept", ram_mem[4], 32'h1234_AB78);
    do_req(32'h0000_0FFC, 32'h0, 4'h0, 1'b0, rd, lat);
    check("hw_readback", rd, 32'hCAFE_2222);

    // out of range read and store
    c0 = ce_cnt; w0 = wr_cnt;
    do_req(32'h0000_1000, 32'h0, 4'h0, 1'b0, rd, lat);
    check("oor_lat", lat, 32'd1);
`ifdef RAMBR_OOR_TRAP_EN
    check("oor_rdata", rd, 32'hDEAD_BEEF);
    check("oor_err", {31'b0, oor_err}, 32'd1);
`else
    check("oor_rdata", rd, 32'h0);
`endif
    check("oor_ce", ce_cnt - c0, 32'd0);
    do_req(32'h0000_2010, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, lat);
    check("oor_st_lat", lat, 32'd1);
    check("oor_st_wr", wr_cnt - w0, 32'd0);
    check("oor_st_ce", ce_cnt - c0, 32'd0);
    check("oor_word4", ram_mem[4], 32'h1234_AB78);

    // back-to-back: read, full store, read
    r0 = rdy_cnt;
    do_req(32'h0000_0010, 32'h0, 4'h0, 1'b0, rd, lat);
    check("b2b_rd_lat", lat, 32'd2);
    check("b2b_rd_data", rd, 32'h1234_AB78);
    do_req(32'h0000_0020, 32'hA5A5_5A5A, 4'hF, 1'b0, rd, lat);
    check("b2b_st_lat", lat, 32'd1);
    check("b2b_st_hold", rd, 32'h1234_AB78);
    do_req(32'h0000_0020, 32'h0, 4'h0, 1'b0, rd, lat);
    check("b2b_rd2_lat", lat, 32'd2);
    check("b2b_rd2_data", rd, 32'hA5A5_5A5A);
    check("b2b_acks", rdy_cnt - r0, 32'd3);
    check("double_ready", dbl_cnt, 32'd0);

    // reset in the middle of a partial store
    do_req(32'h0000_0030, 32'h0BAD_F00D, 4'hF, 1'b0, rd, lat);
    w0 = wr_cnt; r0 = rdy_cnt;
    mem_addr = 32'h0000_0030;
    mem_wdata = 32'h0000_00FF;
    mem_wstrb = 4'b0001;
    mem_valid = 1'b1;
    @(posedge clk); #1;
    check("mid_state_merge", {30'b0, state_dbg}, 32'd2);
    reset = 1'b1;
    #1;
    check("mid_state_idle", {30'b0, state_dbg}, 32'd0);
    check("mid_wre", {31'b0, ram_wre}, 32'd0);
    check("mid_ready", {31'b0, mem_ready}, 32'd0);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_wr", wr_cnt - w0, 32'd0);
    check("mid_acks", rdy_cnt - r0, 32'd0);
    do_req(32'h0000_0030, 32'h0, 4'h0, 1'b0, rd, lat);
    check("mid_readback", rd, 32'h0BAD_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
